// File: rtl/i2c_pkg.sv
// ============================================================================
//  Module  : i2c_pkg
//  Brief   : Shared i2c types and widths for the arbiter and master engine.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [2:0] {
        M_IDLE  = 3'd0,
        M_START = 3'd1,
        M_ADDR  = 3'd2,
        M_DATA  = 3'd3,
        M_ACK   = 3'd4,
        M_STOP  = 3'd5
    } mst_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational round-robin picker, first set bit from ptr upward.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         onehot,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int c_PTR_W = $clog2(NREQ);

    logic [c_PTR_W:0]   w_sum;
    logic [c_PTR_W-1:0] w_pos;

    // Walk from the farthest offset down so the nearest request wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        w_sum  = '0;
        w_pos  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, ptr} + (c_PTR_W + 1)'(i);
            if (w_sum >= (c_PTR_W + 1)'(NREQ)) begin
                w_sum = w_sum - (c_PTR_W + 1)'(NREQ);
            end
            w_pos = w_sum[c_PTR_W-1:0];
            if (req[w_pos]) begin
                onehot        = '0;
                onehot[w_pos] = 1'b1;
                idx           = w_pos;
                any           = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
// ============================================================================
//  Module  : i2c_master_arbiter
//  Brief   : Round-robin sharing of one i2c master among NREQ requesters.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*I2C_ADDR_W-1:0]   req_addr,
    input  logic [NREQ*I2C_DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]              req_rnw,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [I2C_DATA_W-1:0]        rsp_rdata,
    output logic                         rsp_nack,
    output logic                         rsp_timeout,
    output logic                         m_start,
    output logic [I2C_ADDR_W-1:0]        m_addr,
    output logic [I2C_DATA_W-1:0]        m_data,
    output logic                         m_rnw,
    input  logic                         m_busy,
    input  logic                         m_done,
    input  logic                         m_nack,
    input  logic [I2C_DATA_W-1:0]        m_rdata
);

    localparam int                 c_PTR_W   = $clog2(NREQ);
    localparam logic [c_PTR_W-1:0] c_LAST    = c_PTR_W'(NREQ - 1);
    localparam logic [CNT_W-1:0]   c_TO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_PTR_W-1:0] r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [NREQ-1:0]    w_pick_onehot;
    logic [c_PTR_W-1:0] w_pick_idx;
    logic               w_pick_any;
    logic               w_accept;
    logic               w_timeout_hit;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (r_rr_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes are forced low while rst is held so a reset in ISSUE/RESP is silent.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        m_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!m_busy && w_pick_any) begin
                    w_accept    = 1'b1;
                    req_ready   = w_pick_onehot;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_start     = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (m_done || w_timeout_hit) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[r_grant] = 1'b1;
                w_state_nxt        = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (rst) begin
            w_accept  = 1'b0;
            req_ready = '0;
            rsp_valid = '0;
            m_start   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            m_addr      <= '0;
            m_data      <= '0;
            m_rnw       <= 1'b0;
            rsp_rdata   <= '0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grant <= w_pick_idx;
                        m_addr  <= req_addr[w_pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
                        m_data  <= req_data[w_pick_idx*I2C_DATA_W +: I2C_DATA_W];
                        m_rnw   <= req_rnw[w_pick_idx];
                    end
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    // A completion landing on the last allowed cycle still counts as success.
                    if (m_done) begin
                        rsp_rdata   <= m_rnw ? m_rdata : '0;
                        rsp_nack    <= m_nack;
                        rsp_timeout <= 1'b0;
                    end else if (w_timeout_hit) begin
                        rsp_rdata   <= '0;
                        rsp_nack    <= 1'b0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: r_rr_ptr <= (r_grant == c_LAST) ? '0 : r_grant + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
// ============================================================================
//  Module  : tb_i2c_master_arbiter
//  Brief   : Directed self-checking bench for the round-robin i2c arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_arbiter;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [27:0]     req_addr;
    logic [31:0]     req_data;
    logic [3:0]      req_rnw;
    logic [3:0]      req_ready;
    logic [3:0]      rsp_valid;
    logic [7:0]      rsp_rdata;
    logic            rsp_nack;
    logic            rsp_timeout;
    logic            m_start;
    logic [6:0]      m_addr;
    logic [7:0]      m_data;
    logic            m_rnw;
    logic            m_busy;
    logic            m_done;
    logic            m_nack;
    logic [7:0]      m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    i2c_master_arbiter #(
        .NREQ(NREQ), .TIMEOUT(16), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_rnw(req_rnw), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout),
        .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_rnw(m_rnw),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic r);
        req_addr[i*7 +: 7] = a;
        req_data[i*8 +: 8] = d;
        req_rnw[i]         = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111;
        tick(); tick(); settle();
        n_checks++; if (req_ready !== 4'b0)   begin n_errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        n_checks++; if (rsp_valid !== 4'b0)   begin n_errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
        n_checks++; if ({rsp_rdata, rsp_nack, rsp_timeout} !== 10'h0) begin n_errors++; $display("FAIL reset_rsp got %h/%b/%b exp 0", rsp_rdata, rsp_nack, rsp_timeout); end
        n_checks++; if ({m_start, m_addr, m_data, m_rnw} !== 17'h0) begin n_errors++; $display("FAIL reset_master got %b/%h/%h/%b exp 0", m_start, m_addr, m_data, m_rnw); end
        req_valid = 4'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        bit bad;
        set_req(2, 7'h50, 8'hA5, 1'b0);
        req_valid = 4'b0100; settle();
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL wr_ready got %b exp 0100", req_ready); end
        tick(); req_valid = 4'b0; settle();
        n_checks++; if (m_start !== 1'b1) begin n_errors++; $display("FAIL wr_start got %b exp 1", m_start); end
        n_checks++; if ({m_addr, m_data, m_rnw} !== {7'h50, 8'hA5, 1'b0}) begin n_errors++; $display("FAIL wr_payload got %h/%h/%b exp 50/a5/0", m_addr, m_data, m_rnw); end
        bad = 1'b0;
        repeat (10) begin
            tick(); settle();
            if (m_start !== 1'b0 || rsp_valid !== 4'b0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_errors++; $display("FAIL wr_wait_quiet got strobe exp none"); end
        m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'h5A;
        tick(); m_done = 1'b0; settle();
        n_checks++; if (rsp_valid !== 4'b0100) begin n_errors++; $display("FAIL wr_rsp_valid got %b exp 0100", rsp_valid); end
        n_checks++; if ({rsp_rdata, rsp_nack, rsp_timeout} !== 10'h0) begin n_errors++; $display("FAIL wr_rsp got %h/%b/%b exp 00/0/0", rsp_rdata, rsp_nack, rsp_timeout); end
        tick(); settle();
        n_checks++; if (rsp_valid !== 4'b0) begin n_errors++; $display("FAIL wr_rsp_pulse got %b exp 0000", rsp_valid); end
        // All pending: pointer should now sit at 3
        req_valid = 4'b1111; settle();
        n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL wr_ptr_next got %b exp 1000", req_ready); end
        tick(); req_valid = 4'b0;
        tick(); m_done = 1'b1;
        tick(); m_done = 1'b0; req_valid = 4'b0001; settle();
        n_checks++; if ({rsp_valid, req_ready} !== {4'b1000, 4'b0000}) begin n_errors++; $display("FAIL b2b_resp got %b/%b exp 1000/0000", rsp_valid, req_ready); end
        tick(); settle();
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL b2b_accept got %b exp 0001", req_ready); end
        tick(); req_valid = 4'b0;
        tick(); m_done = 1'b1;
        tick(); m_done = 1'b0; settle();
        n_checks++; if (rsp_valid !== 4'b0001) begin n_errors++; $display("FAIL b2b_rsp got %b exp 0001", rsp_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        rst = 1'b1; req_valid = 4'b1111;
        tick(); rst = 1'b0; settle();
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            for (int c = 0; c < 10 && req_ready === 4'b0; c++) begin
                tick(); settle();
            end
            n_checks++; if (req_ready !== exp) begin n_errors++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp); end
            tick(); tick(); tick();
            m_done = 1'b1;
            tick(); m_done = 1'b0; settle();
            n_checks++; if ({rsp_valid, req_ready} !== {exp, 4'b0}) begin n_errors++; $display("FAIL rr_rsp%0d got %b/%b exp %b/0000", k, rsp_valid, req_ready, exp); end
            tick(); settle();
        end
        req_valid = 4'b0;
    endtask

    task automatic test_read_nack();
        set_req(1, 7'h3C, 8'h00, 1'b1);
        req_valid = 4'b0010; settle();
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL rd_ready got %b exp 0010", req_ready); end
        tick(); req_valid = 4'b0; settle();
        n_checks++; if ({m_start, m_addr, m_rnw} !== {1'b1, 7'h3C, 1'b1}) begin n_errors++; $display("FAIL rd_issue got %b/%h/%b exp 1/3c/1", m_start, m_addr, m_rnw); end
        tick(); tick();
        m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'h7E;
        tick(); m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00; settle();
        n_checks++; if (rsp_valid !== 4'b0010) begin n_errors++; $display("FAIL rd_rsp_valid got %b exp 0010", rsp_valid); end
        n_checks++; if ({rsp_rdata, rsp_nack, rsp_timeout} !== {8'h7E, 1'b1, 1'b0}) begin n_errors++; $display("FAIL rd_rsp got %h/%b/%b exp 7e/1/0", rsp_rdata, rsp_nack, rsp_timeout); end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        set_req(3, 7'h11, 8'h22, 1'b1);
        req_valid = 4'b1000; settle();
        n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL to_ready got %b exp 1000", req_ready); end
        tick(); req_valid = 4'b0;
        tick();
        n = 0;
        while (n < 40) begin
            tick(); settle(); n++;
            if (rsp_valid !== 4'b0) break;
        end
        n_checks++; if (n !== 16) begin n_errors++; $display("FAIL to_latency got %0d exp 16", n); end
        n_checks++; if ({rsp_valid, rsp_timeout, rsp_nack, rsp_rdata} !== {4'b1000, 1'b1, 1'b0, 8'h00}) begin n_errors++; $display("FAIL to_rsp got %b/%b/%b/%h exp 1000/1/0/00", rsp_valid, rsp_timeout, rsp_nack, rsp_rdata); end
        tick(); req_valid = 4'b1001; settle();
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL to_ptr_adv got %b exp 0001", req_ready); end
        tick(); req_valid = 4'b0;
        tick(); m_done = 1'b1;
        tick(); m_done = 1'b0; settle();
        n_checks++; if (rsp_valid !== 4'b0001) begin n_errors++; $display("FAIL to_after_rsp got %b exp 0001", rsp_valid); end
        tick();
    endtask

    task automatic test_busy_and_tie();
        set_req(0, 7'h21, 8'h43, 1'b1);
        m_busy = 1'b1; req_valid = 4'b0001; settle();
        n_checks++; if (req_ready !== 4'b0) begin n_errors++; $display("FAIL busy_ready0 got %b exp 0000", req_ready); end
        tick(); settle();
        n_checks++; if ({req_ready, m_start} !== 5'b0) begin n_errors++; $display("FAIL busy_ready1 got %b/%b exp 0000/0", req_ready, m_start); end
        m_busy = 1'b0; settle();
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL busy_release got %b exp 0001", req_ready); end
        tick(); req_valid = 4'b0;
        tick();
        repeat (15) tick();
        m_done = 1'b1; m_rdata = 8'h11;
        tick(); m_done = 1'b0; m_rdata = 8'h00; settle();
        n_checks++; if ({rsp_valid, rsp_timeout, rsp_rdata} !== {4'b0001, 1'b0, 8'h11}) begin n_errors++; $display("FAIL tie_rsp got %b/%b/%h exp 0001/0/11", rsp_valid, rsp_timeout, rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        set_req(2, 7'h66, 8'h77, 1'b0);
        req_valid = 4'b0100; settle();
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL rstw_ready got %b exp 0100", req_ready); end
        tick(); req_valid = 4'b0;
        tick(); tick();
        rst = 1'b1; m_done = 1'b1; settle();
        n_checks++; if ({m_start, rsp_valid} !== 5'b0) begin n_errors++; $display("FAIL rstw_during got %b/%b exp 0/0000", m_start, rsp_valid); end
        tick(); rst = 1'b0; m_done = 1'b0; settle();
        n_checks++; if ({m_start, rsp_valid, m_addr} !== 12'h0) begin n_errors++; $display("FAIL rstw_after got %b/%b/%h exp 0/0000/00", m_start, rsp_valid, m_addr); end
        req_valid = 4'b0101; settle();
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL rstw_ptr got %b exp 0001", req_ready); end
        tick(); req_valid = 4'b0; settle();
        n_checks++; if (m_start !== 1'b1) begin n_errors++; $display("FAIL rstw_start got %b exp 1", m_start); end
        tick(); m_done = 1'b1;
        tick(); m_done = 1'b0; settle();
        n_checks++; if (rsp_valid !== 4'b0001) begin n_errors++; $display("FAIL rstw_rsp got %b exp 0001", rsp_valid); end
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; req_rnw = '0;
        m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
        #1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_nack();
        test_timeout();
        test_busy_and_tie();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
